// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : UART receiver (8 data bits, 1 stop bit, LSB first) using 16x
//            oversampling from a fractional baud accumulator, feeding a small
//            first-word-fall-through FIFO. Sticky error flags for polling.
// Ports    : clk        - system clock, rising edge
//            reset      - synchronous active-high reset
//            baud       - bit rate in Hz (16*baud must be below CLKFREQ)
//            rx         - asynchronous serial input, idle high
//            rd         - pop strobe, ignored while FIFO empty
//            clr_err    - clears overrun / frame_err / parity_err
//            valid      - FIFO not empty
//            rx_data    - FIFO head byte (meaningful only when valid)
//            fifo_count - number of stored bytes
//            overrun    - sticky, a byte was dropped on a full FIFO
//            frame_err  - sticky, stop bit sampled low
//            parity_err - sticky, even-parity mismatch (0 unless enabled)
// Options  : define UART_RX_PARITY_EN to expect an even-parity bit after
//            data bit 7.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int CLKFREQ = 12000000,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              baud,
  input  logic                     rx,
  input  logic                     rd,
  input  logic                     clr_err,
  output logic                     valid,
  output logic [7:0]               rx_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overrun,
  output logic                     frame_err,
  output logic                     parity_err
);

  localparam int          PW       = $clog2(DEPTH);
  localparam logic [35:0] CLK_F    = 36'(CLKFREQ);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  // --------------------------------------------------------------------------
  // Two-flop synchronizer; resets to the idle (high) line level
  // --------------------------------------------------------------------------
  logic rx_meta;
  logic rs;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rs      <= 1'b1;
    end else begin
      rx_meta <= rx;
      rs      <= rx_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Fractional 16x tick generator. Free-running: the start-bit search absorbs
  // up to one tick of phase error instead of realigning the accumulator.
  // acc stays below CLKFREQ and inc is below CLKFREQ, so the sum fits 36 bits.
  // --------------------------------------------------------------------------
  logic [35:0] acc;
  logic [35:0] acc_sum;
  logic        tick;

  assign acc_sum = acc + {baud, 4'b0000};
  assign tick    = (acc_sum >= CLK_F);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (tick) begin
      acc <= acc_sum - CLK_F;
    end else begin
      acc <= acc_sum;
    end
  end

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_WAITHI = 3'd5
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  sc, sc_nx;
  logic [2:0]  idx, idx_nx;
  logic [7:0]  shreg, shreg_nx;
  logic        bad, bad_nx;       // byte must be discarded at the stop bit
  logic        push;              // push attempt, one cycle at stop sample
  logic        set_frame;
`ifdef UART_RX_PARITY_EN
  logic        set_parity;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      sc    <= '0;
      idx   <= '0;
      shreg <= '0;
      bad   <= 1'b0;
    end else begin
      state <= state_nx;
      sc    <= sc_nx;
      idx   <= idx_nx;
      shreg <= shreg_nx;
      bad   <= bad_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    sc_nx     = sc;
    idx_nx    = idx;
    shreg_nx  = shreg;
    bad_nx    = bad;
    push      = 1'b0;
    set_frame = 1'b0;
`ifdef UART_RX_PARITY_EN
    set_parity = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (!rs) begin
          state_nx = S_START;
          sc_nx    = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (sc == 4'd7) begin
            // mid start bit: a high line here was only a glitch
            if (rs) begin
              state_nx = S_IDLE;
            end else begin
              state_nx = S_DATA;
              sc_nx    = '0;
              idx_nx   = '0;
              bad_nx   = 1'b0;
            end
          end else begin
            sc_nx = sc + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          sc_nx = sc + 4'd1;
          if (sc == 4'd15) begin
            shreg_nx[idx] = rs;
            idx_nx        = idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_nx = S_PARITY;
`else
              state_nx = S_STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          sc_nx = sc + 4'd1;
          if (sc == 4'd15) begin
            if ((^shreg) ^ rs) begin
              set_parity = 1'b1;
              bad_nx     = 1'b1;
            end
            state_nx = S_STOP;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          sc_nx = sc + 4'd1;
          if (sc == 4'd15) begin
            if (rs) begin
              push     = !bad;
              state_nx = S_IDLE;
            end else begin
              set_frame = 1'b1;
              state_nx  = S_WAITHI;
            end
          end
        end
      end
      S_WAITHI: begin
        // hold off until the line returns high so a break is not a start bit
        if (rs) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FWFT FIFO
  // --------------------------------------------------------------------------
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic          ovr_set;

  assign valid   = (fifo_count != '0);
  assign full    = (fifo_count == FULL_CNT);
  assign pop     = rd && valid;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign wr_en   = push && (!full || pop);
  assign ovr_set = push && full && !pop;
  assign rx_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= shreg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sticky error flags: a set event wins over clr_err in the same cycle
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end
      if (set_frame) begin
        frame_err <= 1'b1;
      end else if (clr_err) begin
        frame_err <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err <= 1'b0;
    end else if (set_parity) begin
      parity_err <= 1'b1;
    end else if (clr_err) begin
      parity_err <= 1'b0;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Self-checking bench for uart_rx_fifo. Frames are driven on rx at
//            an exact 115200 bit period (3125/3 time units with a 10-unit
//            clock, i.e. 104.17 clk). Good frames push their byte into a
//            scoreboard queue; each pop compares rx_data with the queue head.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int CLKFREQ = 12000000;
  localparam int DEPTH   = 4;

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic [31:0] baud   = 32'd115200;
  logic       rx      = 1'b1;
  logic       rd      = 1'b0;
  logic       clr_err = 1'b0;
  logic       valid;
  logic [7:0] rx_data;
  logic [2:0] fifo_count;
  logic       overrun;
  logic       frame_err;
  logic       parity_err;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic       exp_ovr  = 1'b0;
  logic       seen;

  uart_rx_fifo #(
    .CLKFREQ (CLKFREQ),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .baud       (baud),
    .rx         (rx),
    .rd         (rd),
    .clr_err    (clr_err),
    .valid      (valid),
    .rx_data    (rx_data),
    .fifo_count (fifo_count),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one complete frame; returns at the end of the stop bit, line high.
  task automatic send_frame(input logic [7:0] b, input logic stop_lv, input logic par_ok);
    logic [10:0] bits;
    int          nb;
    longint      t0;
    longint      tgt;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = b;
`ifdef UART_RX_PARITY_EN
    bits[9]   = par_ok ? (^b) : ~(^b);
    bits[10]  = stop_lv;
    nb        = 11;
`else
    bits[9]   = stop_lv;
    nb        = 10;
    if (!par_ok) bits[9] = stop_lv;
`endif
    t0 = longint'($time);
    for (int k = 0; k < nb; k++) begin
      rx  = bits[k];
      tgt = t0 + ((longint'(k) + 1) * 3125) / 3;
      #(tgt - longint'($time));
    end
    rx = 1'b1;
  endtask

  // Good frame: the scoreboard expects it stored, or an overrun when full.
  task automatic send_good(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else                      exp_ovr = 1'b1;
    send_frame(b, 1'b1, 1'b1);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    @(negedge clk);
    check_val({tag, "_valid"}, 32'(valid), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check_val({tag, "_data"}, 32'(rx_data), 32'(e));
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic idle_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    idle_clks(3);
    reset = 1'b0;
    check_val("rst_valid", 32'(valid), 32'd0);
    check_val("rst_count", 32'(fifo_count), 32'd0);
    check_val("rst_ovr",   32'(overrun), 32'd0);
    check_val("rst_ferr",  32'(frame_err), 32'd0);
    check_val("rst_perr",  32'(parity_err), 32'd0);
    idle_clks(20);

    // 1: single byte, then pop
    send_good(8'hA5);
    for (int i = 0; i < 8 && !valid; i++) @(negedge clk);
    check_val("t1_valid_in_time", 32'(valid), 32'd1);
    check_val("t1_count", 32'(fifo_count), 32'd1);
    pop_check("t1");
    check_val("t1_empty_valid", 32'(valid), 32'd0);
    check_val("t1_empty_count", 32'(fifo_count), 32'd0);

    // 2: short low glitch is rejected
    rx = 1'b0;
    idle_clks(30);
    rx = 1'b1;
    idle_clks(250);
    check_val("t2_count", 32'(fifo_count), 32'd0);
    check_val("t2_valid", 32'(valid), 32'd0);
    check_val("t2_ferr",  32'(frame_err), 32'd0);

    // 3: framing error, recovery, clear
    send_frame(8'h3C, 1'b0, 1'b1);
    idle_clks(209);
    send_good(8'h11);
    idle_clks(5);
    check_val("t3_ferr",  32'(frame_err), 32'd1);
    check_val("t3_count", 32'(fifo_count), 32'd1);
    pop_check("t3");
    pulse_clr();
    check_val("t3_ferr_clr", 32'(frame_err), 32'd0);

    // 4: overflow
    for (int b = 1; b <= 5; b++) send_good(8'(b));
    idle_clks(5);
    check_val("t4_count", 32'(fifo_count), 32'(exp_q.size()));
    check_val("t4_ovr",   32'(overrun), 32'(exp_ovr));
    for (int i = 0; i < 4; i++) pop_check("t4");
    check_val("t4_empty", 32'(valid), 32'd0);
    pulse_clr();
    exp_ovr = 1'b0;
    check_val("t4_ovr_clr", 32'(overrun), 32'(exp_ovr));

    // 5: pop in the exact push cycle while full
    for (int b = 8'h21; b <= 8'h24; b++) send_good(8'(b));
    seen = 1'b0;
    fork
      send_frame(8'h77, 1'b1, 1'b1);
      begin
        for (int i = 0; i < 1500 && !seen; i++) begin
          @(negedge clk);
          if (dut.push) begin
            seen = 1'b1;
            check_val("t5_head", 32'(rx_data), 32'(exp_q.pop_front()));
            rd = 1'b1;
            @(negedge clk);
            rd = 1'b0;
          end
        end
      end
    join
    check_val("t5_push_seen", 32'(seen), 32'd1);
    exp_q.push_back(8'h77);
    idle_clks(3);
    check_val("t5_count", 32'(fifo_count), 32'd4);
    check_val("t5_ovr",   32'(overrun), 32'd0);
    for (int i = 0; i < 4; i++) pop_check("t5");
    check_val("t5_empty", 32'(valid), 32'd0);

    // 6: reset in the middle of data bit 3
    send_frame(8'h3C, 1'b0, 1'b1);
    idle_clks(209);
    send_good(8'h99);
    idle_clks(5);
    check_val("t6_pre_count", 32'(fifo_count), 32'd1);
    check_val("t6_pre_ferr",  32'(frame_err), 32'd1);
    rx = 1'b0;
    #1042;
    for (int i = 0; i < 3; i++) begin
      rx = ((i % 2) == 1);   // 0x5A bits 0..2
      #1042;
    end
    rx = 1'b1;               // 0x5A bit 3
    #521;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("t6_valid", 32'(valid), 32'd0);
    check_val("t6_count", 32'(fifo_count), 32'd0);
    check_val("t6_ferr",  32'(frame_err), 32'd0);
    check_val("t6_ovr",   32'(overrun), 32'd0);
    check_val("t6_perr",  32'(parity_err), 32'd0);
    exp_q.delete();
    idle_clks(300);
    send_good(8'h5A);
    idle_clks(5);
    check_val("t6_post_count", 32'(fifo_count), 32'd1);
    pop_check("t6");

`ifdef UART_RX_PARITY_EN
    // parity mismatch: 0x07 has odd weight, parity bit 0 is wrong
    send_frame(8'h07, 1'b1, 1'b0);
    idle_clks(5);
    check_val("par_perr",  32'(parity_err), 32'd1);
    check_val("par_count", 32'(fifo_count), 32'd0);
    check_val("par_ferr",  32'(frame_err), 32'd0);
`else
    check_val("nopar_perr", 32'(parity_err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: time limit reached, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
UART receiver (8 data bits, 1 stop, LSB first) with a small first-word-fall-through FIFO. Feeds received bytes to the j1 io read path, complementing the existing buart transmit use. Uses 16x oversampling from a fractional baud accumulator driven by a runtime baud input. Sticky error flags are provided for software polling.

Parameters:
CLKFREQ, 12000000, system clock frequency in Hz.
DEPTH, 4, FIFO entries; power of 2, minimum 2.

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  synchronous, active-high reset.
baud  input  32  bit rate in Hz; requires 16*baud < CLKFREQ.
rx  input  1  asynchronous serial line, idle high.
rd  input  1  pop strobe; ignored when valid=0.
clr_err  input  1  clears overrun, frame_err and parity_err.
valid  output  1  FIFO not empty.
rx_data  output  8  FIFO head byte; only meaningful when valid=1.
fifo_count  output  $clog2(DEPTH)+1  number of stored bytes.
overrun  output  1  sticky: byte dropped because FIFO was full.
frame_err  output  1  sticky: stop bit sampled low.
parity_err  output  1  sticky parity mismatch; constant 0 without UART_RX_PARITY_EN.

Behaviour:
- Reset, synchronous, takes effect on the next clk edge:
  - valid=0, fifo_count=0, all error flags 0, FSM=IDLE.
  - Accumulator=0, sample counter=0, synchronizer flops=1.
  - rx_data is undefined.
  - Reset asserted mid-byte aborts the byte; nothing is pushed.
- Synchronizer: 2-flop on rx. All decisions use the synchronized value rs.
- Tick generator:
  - 36-bit accumulator acc; inc = baud*16.
  - If acc+inc >= CLKFREQ: acc <= acc+inc-CLKFREQ and tick=1 for one cycle.
  - Otherwise acc <= acc+inc and tick=0.
  - Runs continuously and is not realigned on start-bit detection.
- FSM; sample counter sc is 4 bits and advances only on tick:
  - IDLE: rs==0 -> START, sc=0.
  - START: on the tick where sc==7 (mid start bit), sample rs.
    - rs==1 -> IDLE (glitch rejected, no flag).
    - rs==0 -> DATA, sc=0, bit index=0.
  - DATA: on the tick where sc==15, shift rs into bit[idx]. After idx==7 -> STOP, or PARITY when the option is enabled.
  - STOP: on the tick where sc==15, sample rs.
    - rs==1 -> push the byte, then IDLE.
    - rs==0 -> set frame_err, discard the byte, then WAITHI.
  - WAITHI: stay until rs==1, then IDLE. This avoids treating a break condition as a start bit.
- Push timing: the push occurs in the same cycle as the stop-bit sample tick. valid and fifo_count update on the following edge.
- FIFO:
  - Circular buffer with wrapping read/write pointers of $clog2(DEPTH) bits.
  - rx_data = mem[rptr], combinational read (FWFT).
  - Pop on rd && valid.
  - Push while full with no pop: byte dropped, overrun set.
  - Push and pop in the same cycle while full: both occur, count unchanged, overrun not set.
  - Push and pop in the same cycle while empty is impossible, because pop requires valid.
- Error flags: sticky until clr_err or reset.
  - A set event and clr_err in the same cycle: set wins.
  - rd does not affect the flags.

Optional Feature:
UART_RX_PARITY_EN:
- Defined:
  - Even-parity bit expected after data bit 7. PARITY state samples it on the tick where sc==15.
  - The XOR of the data bits and the parity bit must be 0.
  - Mismatch sets parity_err; the byte is discarded at STOP (stop bit still checked for frame_err).
- Undefined:
  - No PARITY state; DATA goes directly to STOP.
  - parity_err is tied to 0.

Test Plan:
All scenarios use CLKFREQ=12000000, baud=115200, DEPTH=4, with rx driven at an exact bit period of 104.17 clk unless stated.
1. Send 0xA5 8N1 -> valid=1 within 60 clk after the stop-bit midpoint, rx_data=0xA5, fifo_count=1. Then a 1-cycle rd -> valid=0, fifo_count=0.
2. Drive rx low for 30 clk, then high -> no push, fifo_count=0, frame_err=0, FSM back in IDLE.
3. Send 0x3C with the stop bit held low, then rx high for 2 bit times, then 0x11 -> frame_err=1 and only 0x11 is stored. Pulse clr_err -> frame_err=0.
4. Send 0x01..0x05 with no reads -> fifo_count=4, overrun=1. Four rd pulses return 0x01, 0x02, 0x03, 0x04.
5. Fill the FIFO to 4, then assert rd in the exact push cycle of a 5th byte 0x77 -> fifo_count stays 4, overrun=0, 0x77 is the last byte read out.
6. Assert reset for 1 cycle in the middle of data bit 3 -> next cycle valid=0, fifo_count=0, flags=0. A subsequent 0x5A is received correctly.
   - With UART_RX_PARITY_EN: 0x07 sent with parity 0 -> parity_err=1, nothing stored.
